// File: rtl/inst_decode_stage.sv
// inst_decode_stage: registered RV32I decode stage with valid/ready handshake and flush
module inst_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] InstrIn,
    input  logic [31:0] PCIn,
    input  logic        InValid,
    output logic        InReady,
    input  logic        Flush,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [5:0]  ALUControl,
    output logic [31:0] ExtImm,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    output logic [4:0]  Rd,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] PCOut,
    output logic        Illegal
);
    localparam logic [5:0] OP_LUI = 6'd0, OP_AUIPC = 6'd1, OP_JAL = 6'd2, OP_JALR = 6'd3;
    localparam logic [5:0] OP_BEQ = 6'd4, OP_BNE = 6'd5, OP_BLT = 6'd6, OP_BGE = 6'd7, OP_BLTU = 6'd8, OP_BGEU = 6'd9;
    localparam logic [5:0] OP_LB = 6'd10, OP_LH = 6'd11, OP_LW = 6'd12, OP_LBU = 6'd13, OP_LHU = 6'd14;
    localparam logic [5:0] OP_SB = 6'd15, OP_SH = 6'd16, OP_SW = 6'd17;
    localparam logic [5:0] OP_ADDI = 6'd18, OP_SLTI = 6'd19, OP_SLTIU = 6'd20, OP_XORI = 6'd21, OP_ORI = 6'd22;
    localparam logic [5:0] OP_ANDI = 6'd23, OP_SLLI = 6'd24, OP_SRLI = 6'd25, OP_SRAI = 6'd26;
    localparam logic [5:0] OP_ADD = 6'd27, OP_SUB = 6'd28, OP_SLL = 6'd29, OP_SLT = 6'd30, OP_SLTU = 6'd31;
    localparam logic [5:0] OP_XOR = 6'd32, OP_SRL = 6'd33, OP_SRA = 6'd34, OP_OR = 6'd35, OP_AND = 6'd36;
    localparam logic [5:0] OP_FENCE = 6'd37, OP_ECALL = 6'd38, OP_EBREAK = 6'd39;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic [5:0]  alu_dec;
    logic [31:0] imm_dec;
    logic        wr_dec, mr_dec, mw_dec, ill_dec, load;

    logic        valid_q, valid_d;
    logic [5:0]  alu_q, alu_d;
    logic [31:0] imm_q, imm_d, pc_q, pc_d;
    logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic        we_q, we_d, mr_q, mr_d, mw_q, mw_d, ill_q, ill_d;

    assign opc    = InstrIn[6:0];
    assign f3     = InstrIn[14:12];
    assign f7     = InstrIn[31:25];
    assign imm_i  = {{20{InstrIn[31]}}, InstrIn[31:20]};
    assign imm_s  = {{20{InstrIn[31]}}, InstrIn[31:25], InstrIn[11:7]};
    assign imm_b  = {{20{InstrIn[31]}}, InstrIn[7], InstrIn[30:25], InstrIn[11:8], 1'b0};
    assign imm_u  = {InstrIn[31:12], 12'b0};
    assign imm_j  = {{12{InstrIn[31]}}, InstrIn[19:12], InstrIn[20], InstrIn[30:21], 1'b0};
    assign imm_sh = {27'b0, InstrIn[24:20]};

    assign InReady = !valid_q || OutReady;
    assign load    = InValid && InReady && !Flush;

    // combinational decode of the presented instruction; illegal encodings collapse to a harmless FENCE
    always_comb begin
        alu_dec = OP_FENCE;
        imm_dec = imm_i;
        wr_dec  = 1'b0;
        mr_dec  = 1'b0;
        mw_dec  = 1'b0;
        ill_dec = 1'b0;
        case (opc)
            7'b0110111: begin alu_dec = OP_LUI; imm_dec = imm_u; wr_dec = 1'b1; end
            7'b0010111: begin alu_dec = OP_AUIPC; imm_dec = imm_u; wr_dec = 1'b1; end
            7'b1101111: begin alu_dec = OP_JAL; imm_dec = imm_j; wr_dec = 1'b1; end
            7'b1100111: begin alu_dec = OP_JALR; wr_dec = 1'b1; ill_dec = f3 != 3'b000; end
            7'b1100011: begin
                imm_dec = imm_b;
                case (f3)
                    3'b000:  alu_dec = OP_BEQ;
                    3'b001:  alu_dec = OP_BNE;
                    3'b100:  alu_dec = OP_BLT;
                    3'b101:  alu_dec = OP_BGE;
                    3'b110:  alu_dec = OP_BLTU;
                    3'b111:  alu_dec = OP_BGEU;
                    default: ill_dec = 1'b1;
                endcase
            end
            7'b0000011: begin
                mr_dec = 1'b1;
                wr_dec = 1'b1;
                case (f3)
                    3'b000:  alu_dec = OP_LB;
                    3'b001:  alu_dec = OP_LH;
                    3'b010:  alu_dec = OP_LW;
                    3'b100:  alu_dec = OP_LBU;
                    3'b101:  alu_dec = OP_LHU;
                    default: ill_dec = 1'b1;
                endcase
            end
            7'b0100011: begin
                imm_dec = imm_s;
                mw_dec  = 1'b1;
                case (f3)
                    3'b000:  alu_dec = OP_SB;
                    3'b001:  alu_dec = OP_SH;
                    3'b010:  alu_dec = OP_SW;
                    default: ill_dec = 1'b1;
                endcase
            end
            7'b0010011: begin
                wr_dec = 1'b1;
                case (f3)
                    3'b000: alu_dec = OP_ADDI;
                    3'b010: alu_dec = OP_SLTI;
                    3'b011: alu_dec = OP_SLTIU;
                    3'b100: alu_dec = OP_XORI;
                    3'b110: alu_dec = OP_ORI;
                    3'b111: alu_dec = OP_ANDI;
                    3'b001: begin alu_dec = OP_SLLI; imm_dec = imm_sh; ill_dec = f7 != 7'b0000000; end
                    default: begin
                        alu_dec = f7 == 7'b0100000 ? OP_SRAI : OP_SRLI;
                        imm_dec = imm_sh;
                        ill_dec = f7 != 7'b0000000 && f7 != 7'b0100000;
                    end
                endcase
            end
            7'b0110011: begin
                wr_dec = 1'b1;
                case ({f7, f3})
                    10'b0000000_000: alu_dec = OP_ADD;
                    10'b0100000_000: alu_dec = OP_SUB;
                    10'b0000000_001: alu_dec = OP_SLL;
                    10'b0000000_010: alu_dec = OP_SLT;
                    10'b0000000_011: alu_dec = OP_SLTU;
                    10'b0000000_100: alu_dec = OP_XOR;
                    10'b0000000_101: alu_dec = OP_SRL;
                    10'b0100000_101: alu_dec = OP_SRA;
                    10'b0000000_110: alu_dec = OP_OR;
                    10'b0000000_111: alu_dec = OP_AND;
                    default:         ill_dec = 1'b1;
                endcase
            end
            7'b0001111: begin alu_dec = OP_FENCE; ill_dec = f3 != 3'b000; end
            7'b1110011: begin
                alu_dec = InstrIn[20] ? OP_EBREAK : OP_ECALL;
                ill_dec = InstrIn[31:7] != 25'h0 && InstrIn[31:7] != 25'h2000;
            end
            default: ill_dec = 1'b1;
        endcase
        if (ill_dec) begin
            alu_dec = OP_FENCE;
            imm_dec = 32'h0;
            wr_dec  = 1'b0;
            mr_dec  = 1'b0;
            mw_dec  = 1'b0;
        end
    end

    // next state: flush beats load and stall; data registers change only on a load
    always_comb begin
        valid_d = Flush ? 1'b0 : load ? 1'b1 : OutReady ? 1'b0 : valid_q;
        alu_d   = load ? alu_dec : alu_q;
        imm_d   = load ? imm_dec : imm_q;
        rs1_d   = load ? InstrIn[19:15] : rs1_q;
        rs2_d   = load ? InstrIn[24:20] : rs2_q;
        rd_d    = load ? InstrIn[11:7] : rd_q;
        we_d    = load ? wr_dec && InstrIn[11:7] != 5'd0 : we_q;
        mr_d    = load ? mr_dec : mr_q;
        mw_d    = load ? mw_dec : mw_q;
        pc_d    = load ? PCIn : pc_q;
        ill_d   = load ? ill_dec : ill_q;
    end

    // output pipeline register with asynchronous reset to an empty, inert state
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= 1'b0;
            alu_q   <= OP_FENCE;
            imm_q   <= 32'h0;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            rd_q    <= 5'd0;
            we_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            pc_q    <= RESET_PC;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            pc_q    <= pc_d;
            ill_q   <= ill_d;
        end
    end

    assign OutValid   = valid_q;
    assign ALUControl = alu_q;
    assign ExtImm     = imm_q;
    assign Rs1        = rs1_q;
    assign Rs2        = rs2_q;
    assign Rd         = rd_q;
    assign RegWrite   = we_q;
    assign MemRead    = mr_q;
    assign MemWrite   = mw_q;
    assign PCOut      = pc_q;
    assign Illegal    = ill_q;
endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Registered RV32I decode stage that turns a fetched instruction into the operation code, extended immediate, register indices and write-back controls consumed by the execute-stage ALU. It sits between fetch and execute and holds one decoded instruction in an output pipeline register. It uses a valid/ready handshake on both sides, with flush support for taken branches and jumps. Undecodable encodings are flagged, never silently executed.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value driven on PCOut while the stage is empty after reset.

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- InstrIn  in  32  instruction word from fetch
- PCIn  in  32  address of InstrIn
- InValid  in  1  InstrIn/PCIn are valid
- InReady  out  1  stage accepts an instruction this cycle
- Flush  in  1  discard held instruction and the one presented this cycle
- OutValid  out  1  decoded outputs are valid
- OutReady  in  1  execute consumes the outputs this cycle
- ALUControl  out  6  operation code; values are the global.v macros (`LUI … `EBREAK)
- ExtImm  out  32  extended immediate
- Rs1, Rs2, Rd  out  5 each  register indices
- RegWrite  out  1  instruction writes Rd (forced 0 when Rd==0)
- MemRead, MemWrite  out  1 each  load / store
- PCOut  out  32  PC of the held instruction
- Illegal  out  1  held instruction is not a legal RV32I encoding

## Operation
- Decode is combinational from InstrIn; all decoded fields are captured into output registers on a handshake. Outputs change only on a load or a reset.
- Immediate formats:
  - I: sign-extended [31:20].
  - S: {[31:25],[11:7]} sign-extended.
  - B: {[31],[7],[30:25],[11:8],0} sign-extended.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0} sign-extended.
  - Shift-immediates: {27'b0,[24:20]}.
- Opcode/funct3/funct7 map one-to-one onto the ALUControl macros:
  - LUI, AUIPC, JAL, JALR.
  - Six branches, five loads, three stores.
  - Nine OP-IMM operations, ten OP operations.
  - FENCE, ECALL, EBREAK.
- funct7 must be 7'b0000000. The only exception is 7'b0100000, which is legal for SUB, SRA and SRAI. SLLI/SRLI/SRAI additionally require bit[25]=0. Any other funct7 is illegal.
- Illegal encodings set the following. They include unknown opcodes, unused funct3 values, a bad funct7, and InstrIn[1:0]!=2'b11.
  - Illegal=1.
  - ALUControl=`FENCE.
  - RegWrite=0, MemRead=0, MemWrite=0.
  - ExtImm=0.
- RegWrite=1 for LUI, AUIPC, JAL, JALR, loads, OP-IMM and OP, in each case only when Rd!=0. Branches, stores, FENCE, ECALL and EBREAK set RegWrite=0.
- Rs2 is taken from [24:20] for every format. Execute ignores it where it is unused.

## Timing
- Reset (async, immediate):
  - OutValid=0, Illegal=0.
  - ALUControl=`FENCE.
  - ExtImm=0; Rs1=Rs2=Rd=0.
  - RegWrite=MemRead=MemWrite=0.
  - PCOut=RESET_PC.
- InReady = !OutValid || OutReady. It is combinational and independent of InValid and Flush.
- Load occurs when InValid && InReady && !Flush. The outputs hold the decode one cycle after the accepting edge, so latency is 1 cycle.
- Register update at each edge:
  - Flush=1: OutValid←0. Flush wins over a simultaneous load and over a stall.
  - Otherwise, on a load: OutValid←1.
  - Otherwise, if OutReady: OutValid←0.
  - Otherwise: hold.
- Stall: while OutValid && !OutReady, every output is held bit-stable and InReady=0.
- Back-to-back: with OutValid=1 and OutReady=1, a new instruction is accepted in the same cycle. Throughput is one instruction per cycle, with no bubble.
- Data outputs are don't-care while OutValid=0, but they keep their last loaded values; they are not cleared by Flush.

## Test plan
- Reset, then InValid with 0xFFB00093 (addi x1,x0,-5) at PCIn 0x100 → one cycle later:
  - OutValid=1, ALUControl=`ADDI, ExtImm=0xFFFFFFFB.
  - Rs1=0, Rd=1, RegWrite=1, PCOut=0x100.
- Load each of the following with OutReady held at 1; each must be accepted on consecutive cycles with no bubble:
  - 0xFE208CE3 (beq x1,x2,-8) → `BEQ, ExtImm=0xFFFFFFF8, Rs1=1, Rs2=2, RegWrite=0.
  - 0x123452B7 (lui x5,0x12345) → `LUI, ExtImm=0x12345000, Rd=5.
  - 0x40725193 (srai x3,x4,7) → `SRAI, ExtImm=7, Rs1=4, Rd=3.
- Hold OutReady=0 for 3 cycles with InValid=1 → InReady=0 and all outputs bit-stable. Release OutReady → the next instruction is loaded on that edge.
- Drive 0x00000000, then 0x02000033 (bad funct7 on ADD) → each gives Illegal=1, ALUControl=`FENCE, RegWrite=0, MemWrite=0.
- Assert Flush in the same cycle as a valid handshake → next cycle OutValid=0 and the presented instruction is lost. Also check Flush during a stall → OutValid=0.
- Assert RESET mid-stall with OutValid=1 → OutValid=0 and PCOut=RESET_PC immediately, before the next clock edge.
